// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
`timescale 1ns/1ps
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KP_KEYS = KP_ROWS * KP_COLS;

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM,
    HELD,
    RELEASE
  } kp_state_t;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [KP_KEYS-1:0] v);
    return (v != '0) && ((v & (v - KP_KEYS'(1))) == '0);
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines; idles high (no key).
`timescale 1ns/1ps
module keypad_row_sync #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column rotation, row sampling into a frame snapshot,
// and a frame-rate debounce FSM producing a held one-hot key code.
`timescale 1ns/1ps
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KP_ROWS-1:0] row,
  output logic [KP_COLS-1:0] col,
  output logic [KP_KEYS-1:0] onehot,
  output logic               key_valid,
  output logic               key_held
);

  localparam int              DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]      DF         = 4'(DEBOUNCE_FRAMES);

  logic [DW-1:0]        r_dwell;
  logic [1:0]           r_col_idx;
  logic [KP_COLS-1:0]   r_col;
  logic [KP_KEYS-1:0]   r_snap;
  logic                 r_frame_end;
  logic [KP_ROWS-1:0]   w_row_sync;
  logic                 w_dwell_end;

  kp_state_t            r_state, w_state_next;
  logic [KP_KEYS-1:0]   r_cand, w_cand_next;
  logic [3:0]           r_cnt, w_cnt_next;
  logic [KP_KEYS-1:0]   r_onehot, w_onehot_next;
  logic                 r_valid, w_valid_next;
  logic                 r_held, w_held_next;
  logic [3:0]           w_cnt_inc;

  keypad_row_sync #(.W(KP_ROWS)) u_row_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_async (row),
    .o_sync  (w_row_sync)
  );

  assign w_dwell_end = (r_dwell == DWELL_LAST);

  // Column drive is a registered rotating zero so the pins never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell   <= '0;
      r_col_idx <= 2'd0;
      r_col     <= 4'b1110;
    end else if (w_dwell_end) begin
      r_dwell   <= '0;
      r_col_idx <= r_col_idx + 2'd1;
      r_col     <= {r_col[KP_COLS-2:0], r_col[KP_COLS-1]};
    end else begin
      r_dwell   <= r_dwell + DW'(1);
    end
  end

  // Snapshot bits are 1 = pressed; the frame is evaluated one cycle after column 3 lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap      <= '0;
      r_frame_end <= 1'b0;
    end else begin
      r_frame_end <= w_dwell_end && (r_col_idx == 2'd3);
      if (w_dwell_end)
        r_snap[{r_col_idx, 2'b00} +: KP_ROWS] <= ~w_row_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cand   <= '0;
      r_cnt    <= 4'd0;
      r_onehot <= '0;
      r_valid  <= 1'b0;
      r_held   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cand   <= w_cand_next;
      r_cnt    <= w_cnt_next;
      r_onehot <= w_onehot_next;
      r_valid  <= w_valid_next;
      r_held   <= w_held_next;
    end
  end

  assign w_cnt_inc = r_cnt + 4'd1;

  always_comb begin
    w_state_next  = r_state;
    w_cand_next   = r_cand;
    w_cnt_next    = r_cnt;
    w_onehot_next = r_onehot;
    w_valid_next  = 1'b0;
    w_held_next   = r_held;
    if (r_frame_end) begin
      unique case (r_state)
        IDLE: begin
          if (is_onehot(r_snap)) begin
            w_state_next = CONFIRM;
            w_cand_next  = r_snap;
            w_cnt_next   = 4'd1;
          end
        end
        CONFIRM: begin
          if (r_snap == r_cand) begin
            w_cnt_next = w_cnt_inc;
            if (w_cnt_inc == DF) begin
              w_state_next  = HELD;
              w_onehot_next = r_cand;
              w_valid_next  = 1'b1;
              w_held_next   = 1'b1;
              w_cnt_next    = 4'd0;
            end
          end else begin
            w_state_next = IDLE;
            w_cnt_next   = 4'd0;
          end
        end
        HELD: begin
          if (r_snap != r_cand) begin
            w_state_next = RELEASE;
            w_cnt_next   = (r_snap == '0) ? 4'd1 : 4'd0;
          end
        end
        RELEASE: begin
          if (r_snap == '0) begin
            w_cnt_next = w_cnt_inc;
            if (w_cnt_inc == DF) begin
              w_state_next = IDLE;
              w_held_next  = 1'b0;
              w_cnt_next   = 4'd0;
            end
          end else if (r_snap == r_cand) begin
            w_state_next = HELD;
            w_cnt_next   = 4'd0;
          end else begin
            // A different key while releasing never rolls over; wait for all-clear.
            w_cnt_next = 4'd0;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign col       = r_col;
  assign onehot    = r_onehot;
  assign key_valid = r_valid;
  assign key_held  = r_held;

endmodule
